// File: rtl/core2wb_pkg.sv
// Shared types and helpers for the Ibex-to-pipelined-Wishbone bridge.
// Holds the bridge FSM encoding and the outstanding-counter width rule.
package core2wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    // Bits needed to count 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: flags a stalled burst after TIMEOUT response-free cycles.
// With TIMEOUT = 0 the block collapses to a constant, never-expiring output.
module wb_watchdog #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clear, active};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

            logic [W-1:0] count;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (active) begin
                    count <= count + 1'b1;
                end
            end

            // A response in the expiry cycle rescues the burst.
            assign expired = active & ~clear & (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/core2wb_pipe.sv
// Ibex memory interface to pipelined Wishbone B4 master with up to
// MAX_OUTSTANDING in-flight transfers and an optional abort watchdog.
module core2wb_pipe
    import core2wb_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT         = 0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            core_req,
    output logic            core_gnt,
    output logic            core_rvalid,
    output logic            core_err,
    input  logic [AW-1:0]   core_addr,
    input  logic            core_we,
    input  logic [DW/8-1:0] core_be,
    input  logic [DW-1:0]   core_wdata,
    output logic [DW-1:0]   core_rdata,

    output logic            wb_cyc,
    output logic            wb_stb,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_we,
    output logic [DW/8-1:0] wb_sel,
    input  logic            wb_stall,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic [DW-1:0]   wb_dat_i
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic full;
    logic pending;
    logic in_abort;
    logic stb;
    logic gnt;
    logic resp;
    logic wd_clear;
    logic wd_active;
    logic wd_expired;

    assign full     = (cnt == CNT_MAX);
    assign pending  = (cnt != '0);
    assign in_abort = (state == ABORT);

    // Reset gating keeps the bus quiet even before the first clock edge.
    assign stb  = ~rst & core_req & ~full & ~in_abort;
    assign gnt  = stb & ~wb_stall;
    assign resp = ~rst & (wb_ack | wb_err) & pending & (state == BUSY);

    assign wb_adr   = core_addr;
    assign wb_dat_o = core_wdata;
    assign wb_we    = core_we;
    assign wb_sel   = core_be;
    assign wb_stb   = stb;
    assign core_gnt = gnt;
    assign wb_cyc   = ~rst & ~in_abort & (stb | pending);

    // In ABORT every remaining slot is retired as a synthetic error.
    assign core_rvalid = ~rst & (in_abort ? pending : resp);
    assign core_err    = ~rst & (in_abort ? pending : (resp & wb_err));
    assign core_rdata  = in_abort ? '0 : wb_dat_i;

    assign wd_clear  = ~pending | resp;
    assign wd_active = pending & (state == BUSY);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .active  (wd_active),
        .expired (wd_expired)
    );

    // NOTE: defaults first so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_next   = cnt;
        state_next = state;

        if (in_abort) begin
            cnt_next = cnt - CW'(pending);
        end else begin
            cnt_next = cnt + CW'(gnt) - CW'(resp);
        end

        case (state)
            IDLE: begin
                if (gnt) state_next = BUSY;
            end
            BUSY: begin
                if (wd_expired)          state_next = ABORT;
                else if (cnt_next == '0) state_next = IDLE;
            end
            ABORT: begin
                if (cnt_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_core2wb_pipe.sv
// Self-checking bench for core2wb_pipe: directed vector table, hand-written
// timeout / reset sequences, and randomized traffic against a queue model.
module tb_core2wb_pipe;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_gnt;
    logic        core_rvalid;
    logic        core_err;
    logic [31:0] core_addr;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_i;

    int checks   = 0;
    int failures = 0;

    core2wb_pipe #(
        .AW              (32),
        .DW              (32),
        .MAX_OUTSTANDING (MAXO),
        .TIMEOUT         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_err    (core_err),
        .core_addr   (core_addr),
        .core_we     (core_we),
        .core_be     (core_be),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_adr      (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_stall    (wb_stall),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .wb_dat_i    (wb_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    typedef struct packed {
        logic        rst;
        logic        req;
        logic        stall;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        gnt;
        logic        rv;
        logic        cerr;
        logic        cyc;
        logic        stb;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic add(input logic r, req, stall, ack, err, input logic [31:0] dat,
                       input logic gnt, rv, cerr, cyc, stb, input logic [31:0] rdata);
        vecs.push_back('{r, req, stall, ack, err, dat, gnt, rv, cerr, cyc, stb, rdata});
    endtask

    // Applies inputs just after the clock edge; request payload is random.
    task automatic drive(input logic r, req, stall, ack, err, input logic [31:0] dat);
        @(posedge clk);
        #1;
        rst        = r;
        core_req   = req;
        wb_stall   = stall;
        wb_ack     = ack;
        wb_err     = err;
        wb_dat_i   = dat;
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_we    = 1'($urandom_range(0, 1));
        core_be    = 4'($urandom_range(0, 15));
    endtask

    // Samples outputs on the falling edge, mid-cycle.
    task automatic expect_cycle(input string tag, input logic gnt, rv, cerr, cyc, stb,
                                input logic [31:0] rdata);
        @(negedge clk);
        check_bit({tag, ".gnt"},    core_gnt,    gnt);
        check_bit({tag, ".rvalid"}, core_rvalid, rv);
        check_bit({tag, ".err"},    core_err,    cerr);
        check_bit({tag, ".cyc"},    wb_cyc,      cyc);
        check_bit({tag, ".stb"},    wb_stb,      stb);
        if (rv) check({tag, ".rdata"}, core_rdata, rdata);
        check_bit({tag, ".pass"},
                  (wb_adr == core_addr) && (wb_dat_o == core_wdata) &&
                  (wb_we == core_we) && (wb_sel == core_be), 1'b1);
    endtask

    initial begin
        int   due_q[$];
        logic m_resp, m_stb, m_gnt, m_cyc;

        rst = 1'b1; core_req = 1'b0; wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        wb_dat_i = '0; core_addr = '0; core_wdata = '0; core_we = 1'b0; core_be = '0;

        // rst req stall ack err dat | gnt rv cerr cyc stb rdata
        add(1, 1, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);        // reset forces outputs low
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);        // single read issue
        add(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 1, 0, 32'hDEADBEEF); // single read ack
        add(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 32'h0);        // spurious ack ignored
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 0, 0, 32'h0,    0, 0, 0, 1, 1, 32'h0);        // stalled
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);        // stall drops
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0);        // full
        add(0, 1, 0, 1, 0, 32'h11111111, 0, 1, 0, 1, 0, 32'h11111111); // ack does not free slot now
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);
        add(0, 0, 0, 1, 0, 32'h22222222, 0, 1, 0, 1, 0, 32'h22222222);
        add(0, 0, 0, 0, 1, 32'h33333333, 0, 1, 1, 1, 0, 32'h33333333); // error response
        add(0, 0, 0, 1, 1, 32'h0,        0, 0, 0, 0, 0, 32'h0);        // spurious ack+err
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);
        add(0, 1, 0, 1, 0, 32'h44444444, 1, 1, 0, 1, 1, 32'h44444444); // grant + response
        add(0, 1, 0, 1, 0, 32'h55555555, 1, 1, 0, 1, 1, 32'h55555555);
        add(0, 0, 0, 1, 0, 32'h66666666, 0, 1, 0, 1, 0, 32'h66666666);
        add(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);        // burst, 3-cycle latency
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0);
        add(0, 1, 0, 1, 0, 32'hA0A0A0A0, 0, 1, 0, 1, 0, 32'hA0A0A0A0);
        add(0, 1, 0, 1, 0, 32'hA1A1A1A1, 1, 1, 0, 1, 1, 32'hA1A1A1A1);
        add(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'hA4A4A4A4, 0, 1, 0, 1, 0, 32'hA4A4A4A4);
        add(0, 0, 0, 1, 0, 32'hA5A5A5A5, 0, 1, 0, 1, 0, 32'hA5A5A5A5);
        add(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].stall, vecs[i].ack, vecs[i].err, vecs[i].dat);
            expect_cycle($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rv, vecs[i].cerr,
                         vecs[i].cyc, vecs[i].stb, vecs[i].rdata);
        end

        // Watchdog abort: two transfers never answered.
        drive(0, 1, 0, 0, 0, 32'h0); expect_cycle("to_g0", 1, 0, 0, 1, 1, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0); expect_cycle("to_g1", 1, 0, 0, 1, 1, 32'h0);
        for (int i = 2; i <= 8; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            expect_cycle($sformatf("to_wait%0d", i), 0, 0, 0, 1, 0, 32'h0);
        end
        drive(0, 1, 0, 0, 0, 32'h0);         expect_cycle("to_abort0", 0, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 1, 0, 32'hFFFFFFFF);  expect_cycle("to_abort1", 0, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 1, 0, 32'hFFFFFFFF);  expect_cycle("to_idle",   1, 0, 0, 1, 1, 32'h0);
        drive(0, 0, 0, 1, 0, 32'h0BADF00D);  expect_cycle("to_after",  0, 1, 0, 1, 0, 32'h0BADF00D);
        drive(0, 0, 0, 0, 0, 32'h0);         expect_cycle("to_quiet",  0, 0, 0, 0, 0, 32'h0);

        // Reset in the middle of a full burst drops everything silently.
        drive(0, 1, 0, 0, 0, 32'h0);         expect_cycle("rb_g0",   1, 0, 0, 1, 1, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0);         expect_cycle("rb_g1",   1, 0, 0, 1, 1, 32'h0);
        drive(1, 1, 0, 1, 0, 32'h77777777);  expect_cycle("rb_rst",  0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 0, 32'h88888888);  expect_cycle("rb_late", 0, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0);         expect_cycle("rb_req",  1, 0, 0, 1, 1, 32'h0);
        drive(0, 0, 0, 1, 0, 32'hDEADBEEF);  expect_cycle("rb_ack",  0, 1, 0, 1, 0, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 32'h0);         expect_cycle("rb_done", 0, 0, 0, 0, 0, 32'h0);

        // Random traffic: the model is a queue of in-flight transfers with due times.
        for (int t = 0; t < 600; t++) begin
            logic ack, err;
            ack = 1'b0;
            err = 1'b0;
            if (due_q.size() != 0 && due_q[0] <= t) begin
                case ($urandom_range(0, 7))
                    0:       err = 1'b1;
                    1:       begin ack = 1'b1; err = 1'b1; end
                    default: ack = 1'b1;
                endcase
            end else if (due_q.size() == 0 && $urandom_range(0, 9) == 0) begin
                ack = 1'b1;
            end
            drive(0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), ack, err, $urandom);

            @(negedge clk);
            m_resp = (wb_ack | wb_err) && (due_q.size() != 0);
            m_stb  = core_req && (due_q.size() < MAXO);
            m_gnt  = m_stb && !wb_stall;
            m_cyc  = m_stb || (due_q.size() != 0);
            check_bit("rnd.gnt",    core_gnt,    m_gnt);
            check_bit("rnd.stb",    wb_stb,      m_stb);
            check_bit("rnd.cyc",    wb_cyc,      m_cyc);
            check_bit("rnd.rvalid", core_rvalid, m_resp);
            check_bit("rnd.err",    core_err,    m_resp && wb_err);
            if (m_resp) check("rnd.rdata", core_rdata, wb_dat_i);
            check("rnd.adr", wb_adr, core_addr);
            if (m_resp) void'(due_q.pop_front());
            if (m_gnt) due_q.push_back(t + 1 + $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
